// File: rtl/sc_spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM encoding, byte size, command field widths.
package sc_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int BITS_PER_BYTE = 8;
  localparam int CS_W          = 2;
  localparam int LEN_W         = 16;

endpackage

// File: rtl/sc_spi_shreg.sv
// 8-bit SPI TX/RX shift register; TX advances on i_tx_adv, RX samples on i_rx_smp, order set by i_lsb_first.
module sc_spi_shreg
  import sc_spi_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic [BITS_PER_BYTE-1:0] i_load_dat,
  input  logic                     i_lsb_first,
  input  logic                     i_tx_adv,
  input  logic                     i_rx_smp,
  input  logic                     i_miso,
  output logic                     o_first_bit,
  output logic                     o_next_bit,
  output logic [BITS_PER_BYTE-1:0] o_rx_dat
);

  logic [BITS_PER_BYTE-1:0] r_tx;
  logic [BITS_PER_BYTE-1:0] r_rx;

  // The bit on the wire is the end of r_tx; o_next_bit is its neighbour, driven after the shift.
  assign o_first_bit = i_lsb_first ? i_load_dat[0] : i_load_dat[BITS_PER_BYTE-1];
  assign o_next_bit  = i_lsb_first ? r_tx[1] : r_tx[BITS_PER_BYTE-2];
  assign o_rx_dat    = r_rx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx <= '0;
      r_rx <= '0;
    end else begin
      if (i_load) begin
        r_tx <= i_load_dat;
      end else if (i_tx_adv) begin
        r_tx <= i_lsb_first ? {1'b0, r_tx[BITS_PER_BYTE-1:1]} : {r_tx[BITS_PER_BYTE-2:0], 1'b0};
      end
      if (i_rx_smp) begin
        r_rx <= i_lsb_first ? {i_miso, r_rx[BITS_PER_BYTE-1:1]} : {r_rx[BITS_PER_BYTE-2:0], i_miso};
      end
    end
  end

endmodule

// File: rtl/sc_spi_xfer_seq.sv
// SPI mode-0 transfer sequencer driving sc_spi_scg's CLK_ENABLE one byte at a time.
// Optional SC_SPI_SEQ_LSB_FIRST_EN adds CMD_LSB_FIRST for per-command bit order.
module sc_spi_xfer_seq
  import sc_spi_pkg::*;
#(
  parameter int NUM_CS   = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              SRCCLK,
  input  logic              SYSRST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [CS_W-1:0]   CMD_CS,
  input  logic [LEN_W-1:0]  CMD_LEN,
`ifdef SC_SPI_SEQ_LSB_FIRST_EN
  input  logic              CMD_LSB_FIRST,
`endif
  input  logic              TX_VALID,
  output logic              TX_READY,
  input  logic [7:0]        TX_DATA,
  output logic              RX_VALID,
  input  logic              RX_READY,
  output logic [7:0]        RX_DATA,
  output logic              CLK_ENABLE,
  input  logic              SPICLK,
  output logic [NUM_CS-1:0] SPI_CSB,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic              BUSY,
  output logic              DONE
);

  state_t           r_state;
  logic             r_spiclk_q;
  logic [LEN_W-1:0] r_len_cnt;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_wait_cnt;

  logic       w_rise;
  logic       w_fall;
  logic       w_cmd_hs;
  logic       w_load;
  logic       w_tx_adv;
  logic       w_rx_smp;
  logic       w_lsb;
  logic       w_first_bit;
  logic       w_next_bit;
  logic [7:0] w_rx_byte;

  assign w_rise   = SPICLK & ~r_spiclk_q;
  assign w_fall   = ~SPICLK & r_spiclk_q;
  assign w_cmd_hs = (r_state == ST_IDLE) && CMD_VALID && CMD_READY;
  // A byte only starts once the RX slot is empty or being drained this cycle.
  assign w_load   = (r_state == ST_LOAD) && TX_VALID && (!RX_VALID || RX_READY);
  assign w_tx_adv = (r_state == ST_SHIFT) && w_fall && (r_bit_cnt < 4'(BITS_PER_BYTE));
  assign w_rx_smp = (r_state == ST_SHIFT) && w_rise;

`ifdef SC_SPI_SEQ_LSB_FIRST_EN
  logic r_lsb;
  always_ff @(posedge SRCCLK or posedge SYSRST) begin
    if (SYSRST) begin
      r_lsb <= 1'b0;
    end else if (w_cmd_hs) begin
      r_lsb <= CMD_LSB_FIRST;
    end
  end
  assign w_lsb = r_lsb;
`else
  assign w_lsb = 1'b0;
`endif

  sc_spi_shreg u_shreg (
    .i_clk       (SRCCLK),
    .i_rst       (SYSRST),
    .i_load      (w_load),
    .i_load_dat  (TX_DATA),
    .i_lsb_first (w_lsb),
    .i_tx_adv    (w_tx_adv),
    .i_rx_smp    (w_rx_smp),
    .i_miso      (SPI_MISO),
    .o_first_bit (w_first_bit),
    .o_next_bit  (w_next_bit),
    .o_rx_dat    (w_rx_byte)
  );

  always_ff @(posedge SRCCLK or posedge SYSRST) begin
    if (SYSRST) begin
      r_state    <= ST_IDLE;
      r_spiclk_q <= 1'b0;
      r_len_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      CMD_READY  <= 1'b0;
      TX_READY   <= 1'b0;
      RX_VALID   <= 1'b0;
      RX_DATA    <= '0;
      CLK_ENABLE <= 1'b0;
      SPI_CSB    <= '1;
      SPI_MOSI   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      r_spiclk_q <= SPICLK;
      TX_READY   <= 1'b0;
      DONE       <= 1'b0;
      if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          CMD_READY <= 1'b1;
          BUSY      <= 1'b0;
          if (w_cmd_hs) begin
            CMD_READY  <= 1'b0;
            BUSY       <= 1'b1;
            r_len_cnt  <= CMD_LEN;
            r_wait_cnt <= '0;
            // An out-of-range index matches no bit, so the bytes run with every CSB high.
            for (int i = 0; i < NUM_CS; i++) begin
              SPI_CSB[i] <= (CMD_CS != CS_W'(i));
            end
            // LOAD adds one cycle before CLK_ENABLE, so SETUP covers the remaining CS_SETUP-1.
            r_state <= (CS_SETUP > 1) ? ST_SETUP : ST_LOAD;
          end
        end
        ST_SETUP: begin
          if (r_wait_cnt == 8'(CS_SETUP - 2)) begin
            r_state <= ST_LOAD;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_LOAD: begin
          if (w_load) begin
            TX_READY   <= 1'b1;
            SPI_MOSI   <= w_first_bit;
            CLK_ENABLE <= 1'b1;
            r_bit_cnt  <= '0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          if (w_tx_adv) begin
            SPI_MOSI <= w_next_bit;
          end
          if (w_fall && (r_bit_cnt == 4'(BITS_PER_BYTE))) begin
            CLK_ENABLE <= 1'b0;
            RX_DATA    <= w_rx_byte;
            RX_VALID   <= 1'b1;
            if (r_len_cnt == '0) begin
              r_wait_cnt <= '0;
              r_state    <= ST_HOLD;
            end else begin
              r_len_cnt <= r_len_cnt - 1'b1;
              r_state   <= ST_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (r_wait_cnt == 8'(CS_HOLD - 1)) begin
            SPI_CSB   <= '1;
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            CMD_READY <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_spi_xfer_seq.sv
// Bench for sc_spi_xfer_seq with a behavioural sc_spi_scg (HIGH=2, LOW=2) and a TX source / RX sink.
module tb_sc_spi_xfer_seq;

  localparam int NUM_CS   = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int SCG_HIGH = 2;
  localparam int SCG_LOW  = 2;

  logic              SRCCLK = 1'b0;
  logic              SYSRST = 1'b1;
  logic              CMD_VALID, CMD_READY;
  logic [1:0]        CMD_CS;
  logic [15:0]       CMD_LEN;
  logic              TX_VALID, TX_READY;
  logic [7:0]        TX_DATA;
  logic              RX_VALID, RX_READY;
  logic [7:0]        RX_DATA;
  logic              CLK_ENABLE;
  logic              SPICLK = 1'b0;
  logic [NUM_CS-1:0] SPI_CSB;
  logic              SPI_MOSI, SPI_MISO;
  logic              BUSY, DONE;
`ifdef SC_SPI_SEQ_LSB_FIRST_EN
  logic              CMD_LSB_FIRST;
`endif

  always #5 SRCCLK = ~SRCCLK;

  sc_spi_xfer_seq #(.NUM_CS(NUM_CS), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .SRCCLK(SRCCLK), .SYSRST(SYSRST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_CS(CMD_CS), .CMD_LEN(CMD_LEN),
`ifdef SC_SPI_SEQ_LSB_FIRST_EN
    .CMD_LSB_FIRST(CMD_LSB_FIRST),
`endif
    .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_DATA(TX_DATA),
    .RX_VALID(RX_VALID), .RX_READY(RX_READY), .RX_DATA(RX_DATA),
    .CLK_ENABLE(CLK_ENABLE), .SPICLK(SPICLK), .SPI_CSB(SPI_CSB),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .BUSY(BUSY), .DONE(DONE)
  );

  // Clock generator model: starts low, LOW cycles low then HIGH cycles high, stops low when disabled.
  int scg_cnt = 0;
  always @(posedge SRCCLK) begin
    if (!CLK_ENABLE) begin
      SPICLK  <= 1'b0;
      scg_cnt <= 0;
    end else if (scg_cnt == (SPICLK ? SCG_HIGH : SCG_LOW) - 1) begin
      SPICLK  <= ~SPICLK;
      scg_cnt <= 0;
    end else begin
      scg_cnt <= scg_cnt + 1;
    end
  end

  logic [1:0] miso_mode;
  assign SPI_MISO = (miso_mode == 2'd0) ? SPI_MOSI : (miso_mode == 2'd1);

  logic [7:0] tx_buf [0:3];
  int         tx_start, tx_n, tx_idx;
  logic       tx_en;
  int         txr_cnt = 0;
  assign tx_idx   = txr_cnt - tx_start;
  assign TX_VALID = tx_en && (tx_idx < tx_n);
  assign TX_DATA  = tx_buf[tx_idx[1:0]];

  // Monitor: owns all the event counters; tests take snapshots before each transfer.
  int   cyc = 0, rises = 0, done_cnt = 0, rx_n = 0, mosi_n = 0, csb_bad = 0;
  int   setup_gap = 0, hold_gap = 0, last_stop = 0, csb_low_cyc = 0;
  logic setup_pend = 1'b0, prev_spiclk = 1'b0, prev_clken = 1'b0, prev_csb_idle = 1'b1;
  logic mon_csb_en;
  logic [NUM_CS-1:0] exp_csb;
  logic [7:0] rx_log [0:63];
  logic       mosi_log [0:511];

  always @(negedge SRCCLK) begin
    cyc         <= cyc + 1;
    prev_spiclk <= SPICLK;
    if (SPICLK && !prev_spiclk) begin
      rises                <= rises + 1;
      mosi_log[mosi_n[8:0]] <= SPI_MOSI;
      mosi_n               <= mosi_n + 1;
    end
    if (TX_READY) txr_cnt <= txr_cnt + 1;
    if (DONE) done_cnt <= done_cnt + 1;
    if (RX_VALID && RX_READY) begin
      rx_log[rx_n[5:0]] <= RX_DATA;
      rx_n              <= rx_n + 1;
    end
    prev_clken <= CLK_ENABLE;
    if (prev_clken && !CLK_ENABLE) last_stop <= cyc;
    if (!prev_clken && CLK_ENABLE && setup_pend) begin
      setup_gap  <= cyc - csb_low_cyc;
      setup_pend <= 1'b0;
    end
    prev_csb_idle <= &SPI_CSB;
    if (prev_csb_idle && !(&SPI_CSB)) begin
      csb_low_cyc <= cyc;
      setup_pend  <= 1'b1;
    end
    if (!prev_csb_idle && (&SPI_CSB)) hold_gap <= cyc - last_stop;
    if (mon_csb_en && BUSY && (SPI_CSB !== exp_csb)) csb_bad <= csb_bad + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mosi_byte(input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = mosi_log[9'(s + i)];
    return b;
  endfunction

  int b_rises, b_done, b_rx, b_mosi, b_csb;

  task automatic start_cmd(input logic [1:0] cs, input logic [15:0] len);
    int t = 0;
    CMD_CS    = cs;
    CMD_LEN   = len;
    CMD_VALID = 1'b1;
    while (!CMD_READY && t < 100) begin
      @(negedge SRCCLK);
      t++;
    end
    if (!CMD_READY) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge SRCCLK);
    #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic begin_xfer(input logic [1:0] cs, input logic [15:0] len,
                            input logic [1:0] mode, input logic [NUM_CS-1:0] csb_e);
    b_rises    = rises;
    b_done     = done_cnt;
    b_rx       = rx_n;
    b_mosi     = mosi_n;
    b_csb      = csb_bad;
    tx_start   = txr_cnt;
    miso_mode  = mode;
    exp_csb    = csb_e;
    mon_csb_en = 1'b1;
    start_cmd(cs, len);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done_cnt == b_done && t < 3000) begin
      @(negedge SRCCLK);
      t++;
    end
    if (done_cnt == b_done) $display("FAIL %s_done_timeout: got 0 DONE pulses, expected 1", name);
    if (done_cnt == b_done) n_fail++;
    n_tests++;
    repeat (3) @(posedge SRCCLK);
    #1;
  endtask

  typedef struct packed {
    logic [1:0]  cs;
    logic [15:0] len;
    logic [1:0]  mode;
    logic [3:0]  csb;
    logic [31:0] nbytes;
    logic [23:0] tx;
    logic [23:0] rx;
    logic [31:0] rises;
  } vec_t;

  vec_t vecs [0:3];

  initial begin
    int t, bad;
    vecs[0] = '{cs:2'd1, len:16'd0, mode:2'd0, csb:4'b1101, nbytes:1, tx:24'h0000A5, rx:24'h0000A5, rises:8};
    vecs[1] = '{cs:2'd2, len:16'd2, mode:2'd1, csb:4'b1011, nbytes:3, tx:24'h030201, rx:24'hFFFFFF, rises:24};
    vecs[2] = '{cs:2'd0, len:16'd1, mode:2'd2, csb:4'b1110, nbytes:2, tx:24'h00C33C, rx:24'h000000, rises:16};
    vecs[3] = '{cs:2'd3, len:16'd1, mode:2'd0, csb:4'b0111, nbytes:2, tx:24'h007E81, rx:24'h007E81, rises:16};

    CMD_VALID = 1'b0; CMD_CS = 2'd0; CMD_LEN = 16'd0; RX_READY = 1'b1;
    tx_en = 1'b0; tx_n = 0; tx_start = 0; miso_mode = 2'd0; mon_csb_en = 1'b0; exp_csb = '1;
`ifdef SC_SPI_SEQ_LSB_FIRST_EN
    CMD_LSB_FIRST = 1'b0;
`endif

    repeat (3) @(posedge SRCCLK);
    #1;
    chk("rst_cmd_ready", CMD_READY, 0);
    chk("rst_tx_ready", TX_READY, 0);
    chk("rst_rx_valid", RX_VALID, 0);
    chk("rst_rx_data", RX_DATA, 0);
    chk("rst_clk_enable", CLK_ENABLE, 0);
    chk("rst_csb", SPI_CSB, 4'hF);
    chk("rst_mosi", SPI_MOSI, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    SYSRST = 1'b0;
    repeat (2) @(posedge SRCCLK);
    #1;
    chk("idle_cmd_ready", CMD_READY, 1);

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 3; k++) tx_buf[k] = vecs[v].tx[8*k +: 8];
      tx_n = vecs[v].nbytes;
      tx_en = 1'b1;
      begin_xfer(vecs[v].cs, vecs[v].len, vecs[v].mode, vecs[v].csb);
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_rises", v), rises - b_rises, vecs[v].rises);
      chk($sformatf("vec%0d_tx_ready", v), txr_cnt - tx_start, vecs[v].nbytes);
      chk($sformatf("vec%0d_done_pulses", v), done_cnt - b_done, 1);
      chk($sformatf("vec%0d_csb_glitch", v), csb_bad - b_csb, 0);
      chk($sformatf("vec%0d_setup", v), setup_gap, CS_SETUP);
      chk($sformatf("vec%0d_hold", v), hold_gap, CS_HOLD);
      chk($sformatf("vec%0d_rx_count", v), rx_n - b_rx, vecs[v].nbytes);
      for (int k = 0; k < vecs[v].nbytes; k++) begin
        chk($sformatf("vec%0d_rx%0d", v, k), rx_log[6'(b_rx + k)], vecs[v].rx[8*k +: 8]);
        chk($sformatf("vec%0d_mosi%0d", v, k), mosi_byte(b_mosi + 8*k), vecs[v].tx[8*k +: 8]);
      end
      chk($sformatf("vec%0d_busy_end", v), BUSY, 0);
      chk($sformatf("vec%0d_csb_end", v), SPI_CSB, 4'hF);
    end

    // RX slot held full: the second byte must wait; a CMD offered meanwhile is ignored.
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_n = 2; tx_en = 1'b1; RX_READY = 1'b0;
    begin_xfer(2'd0, 16'd1, 2'd0, 4'b1110);
    t = 0;
    while (!RX_VALID && t < 500) begin
      @(negedge SRCCLK);
      t++;
    end
    chk("rxfull_rx_valid", RX_VALID, 1);
    CMD_CS = 2'd3; CMD_VALID = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge SRCCLK);
      if (CLK_ENABLE || TX_READY || CMD_READY || !RX_VALID) bad++;
    end
    CMD_VALID = 1'b0;
    chk("rxfull_stalled", bad, 0);
    chk("rxfull_rx_data", RX_DATA, 8'h11);
    chk("rxfull_rises", rises - b_rises, 8);
    chk("rxfull_tx_ready", txr_cnt - tx_start, 1);
    RX_READY = 1'b1;
    wait_done("rxfull");
    chk("rxfull_rx_count", rx_n - b_rx, 2);
    chk("rxfull_rx0", rx_log[6'(b_rx)], 8'h11);
    chk("rxfull_rx1", rx_log[6'(b_rx + 1)], 8'h22);
    chk("rxfull_rises_end", rises - b_rises, 16);
    chk("rxfull_csb_glitch", csb_bad - b_csb, 0);
    chk("rxfull_done_pulses", done_cnt - b_done, 1);

    // TX starvation between bytes.
    tx_buf[0] = 8'h5A; tx_buf[1] = 8'h96; tx_n = 2; tx_en = 1'b1;
    begin_xfer(2'd1, 16'd1, 2'd0, 4'b1101);
    t = 0;
    while (txr_cnt == tx_start && t < 500) begin
      @(negedge SRCCLK);
      t++;
    end
    tx_en = 1'b0;
    t = 0;
    while (!((rises - b_rises) >= 8 && !CLK_ENABLE) && t < 500) begin
      @(negedge SRCCLK);
      t++;
    end
    chk("starve_first_byte", rises - b_rises, 8);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge SRCCLK);
      if (SPICLK || CLK_ENABLE || TX_READY || (SPI_CSB !== 4'b1101) || !BUSY) bad++;
    end
    chk("starve_paused", bad, 0);
    tx_en = 1'b1;
    wait_done("starve");
    chk("starve_rx0", rx_log[6'(b_rx)], 8'h5A);
    chk("starve_rx1", rx_log[6'(b_rx + 1)], 8'h96);
    chk("starve_rises", rises - b_rises, 16);
    chk("starve_mosi1", mosi_byte(b_mosi + 8), 8'h96);
    chk("starve_csb_glitch", csb_bad - b_csb, 0);

    // Reset mid-byte aborts without DONE, then a fresh command completes.
    tx_buf[0] = 8'hF0; tx_n = 1; tx_en = 1'b1;
    begin_xfer(2'd2, 16'd0, 2'd0, 4'b1011);
    t = 0;
    while ((rises - b_rises) < 3 && t < 500) begin
      @(negedge SRCCLK);
      t++;
    end
    chk("abort_reached_3_rises", rises - b_rises, 3);
    SYSRST = 1'b1;
    #1;
    chk("abort_csb", SPI_CSB, 4'hF);
    chk("abort_clk_enable", CLK_ENABLE, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_cmd_ready", CMD_READY, 0);
    repeat (5) @(negedge SRCCLK);
    chk("abort_no_done", done_cnt - b_done, 0);
    chk("abort_no_rx", rx_n - b_rx, 0);
    @(posedge SRCCLK);
    #1;
    SYSRST = 1'b0;
    tx_buf[0] = 8'h3C; tx_n = 1; tx_en = 1'b1;
    begin_xfer(2'd1, 16'd0, 2'd0, 4'b1101);
    wait_done("after_abort");
    chk("after_abort_rx", rx_log[6'(b_rx)], 8'h3C);
    chk("after_abort_rises", rises - b_rises, 8);
    chk("after_abort_done", done_cnt - b_done, 1);

`ifdef SC_SPI_SEQ_LSB_FIRST_EN
    CMD_LSB_FIRST = 1'b1;
    tx_buf[0] = 8'h01; tx_n = 1; tx_en = 1'b1;
    begin_xfer(2'd0, 16'd0, 2'd0, 4'b1110);
    CMD_LSB_FIRST = 1'b0;
    wait_done("lsb");
    chk("lsb_mosi_order", mosi_byte(b_mosi), 8'h80);
    chk("lsb_rx", rx_log[6'(b_rx)], 8'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_spi_xfer_seq.md
Name: sc_spi_xfer_seq

Overview:
- Transfer sequencer for the SPI clock generator (sc_spi_scg). Both blocks run on the same SRCCLK.
- Accepts a command: chip-select index and byte count. Asserts the selected CSB with setup/hold spacing.
- Gates CLK_ENABLE one byte at a time, shifts TX bytes out on MOSI and captures MISO into RX bytes.
- Sits between the register/FIFO front end and the SPI pins.

Parameters:
- NUM_CS, 4, number of chip selects (CMD_CS width is 2, so NUM_CS ≤ 4).
- CS_SETUP, 2, SRCCLK cycles from CSB low to the first CLK_ENABLE (≥1).
- CS_HOLD, 2, SRCCLK cycles from the last clock stop to CSB high (≥1).

Ports:
- SRCCLK  in  1  system clock
- SYSRST  in  1  asynchronous reset, active-high
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted when VALID&READY
- CMD_CS  in  2  chip-select index
- CMD_LEN  in  16  byte count minus 1
- TX_VALID  in  1  TX byte available
- TX_READY  out  1  TX byte consumed
- TX_DATA  in  8  byte to send
- RX_VALID  out  1  received byte held
- RX_READY  in  1  RX byte consumed
- RX_DATA  out  8  received byte
- CLK_ENABLE  out  1  to sc_spi_scg
- SPICLK  in  1  from sc_spi_scg
- SPI_CSB  out  NUM_CS  chip selects, active-low
- SPI_MOSI  out  1  serial out
- SPI_MISO  in  1  serial in
- BUSY  out  1  state ≠ IDLE
- DONE  out  1  one-cycle pulse at transfer end

Behaviour:
- Reset values (async, immediate): CMD_READY=0, TX_READY=0, RX_VALID=0, RX_DATA=0, CLK_ENABLE=0, SPI_CSB=all 1, SPI_MOSI=0, BUSY=0, DONE=0, state=IDLE. Reset mid-transfer aborts with no DONE.
- All outputs are registered. spiclk_q registers SPICLK.
  - rise = SPICLK & !spiclk_q
  - fall = !SPICLK & spiclk_q
- Constraint on sc_spi_scg: CLK_WIDTH_HIGH ≥ 1 and CLK_WIDTH_LOW ≥ 2. This guarantees CLK_ENABLE drops before the next rising edge. Behaviour outside this constraint is undefined.
- SPI mode 0 only: SPICLK idles low, MISO is sampled on rise, MOSI changes after fall.
- FSM:
  - IDLE: CMD_READY=1. On handshake, latch CS and LEN into len_cnt, drive CSB[CMD_CS]=0, go to SETUP. CMD_CS ≥ NUM_CS: command is accepted, no CSB asserts, bytes are still clocked.
  - SETUP: count CS_SETUP cycles, then go to LOAD.
  - LOAD: wait until TX_VALID and (RX_VALID==0 or RX_READY). Then pulse TX_READY for one cycle, load the shift register, drive MOSI with the MSB, set CLK_ENABLE=1, clear bit_cnt, go to SHIFT.
  - SHIFT:
    - On each rise, shift SPI_MISO into the rx shift register and increment bit_cnt.
    - On a fall with bit_cnt<8, drive the next TX bit.
    - On the fall after the 8th rise: CLK_ENABLE=0, RX_DATA=rx shift register, RX_VALID=1.
    - Then if len_cnt==0 go to HOLD; else decrement len_cnt and go to LOAD.
  - HOLD: count CS_HOLD cycles, then set CSB all 1, pulse DONE, go to IDLE.
- RX_VALID stays high until RX_READY. The next byte does not start while the RX slot is occupied, so bytes are never lost. The clock simply pauses.
- TX starvation in LOAD: the clock stays stopped, CSB stays asserted, and the FSM waits indefinitely.
- Minimum inter-byte gap: 1 SRCCLK cycle plus the scg start behaviour.
- Length range: CMD_LEN=0 is one byte, CMD_LEN=16'hFFFF is 65536 bytes. len_cnt never wraps.
- CMD_VALID while BUSY: ignored because CMD_READY=0.

Optional Feature:
- Macro: SC_SPI_SEQ_LSB_FIRST_EN.
- Defined: adds input CMD_LSB_FIRST (1 bit), latched at command accept. When 1, TX shifts out bit 0 first and RX assembles bit 0 first.
- Undefined: the port is absent and transfers are always MSB first.

Decomposition:
- Shared package sc_spi_pkg:
  - state encoding constants (IDLE, SETUP, LOAD, SHIFT, HOLD)
  - bit-count constant 8
  - CMD_CS and CMD_LEN width constants
- One natural sub-module, sc_spi_shreg: the 8-bit TX/RX shift register with edge-enable and order inputs.
- FSM and counters stay in the top module.

Test Plan:
- scg HIGH=2, LOW=2; CMD_CS=1, CMD_LEN=0, TX=8'hA5, MISO loopback from MOSI → CSB[1] low for the transfer; MOSI sequence 1,0,1,0,0,1,0,1; RX_DATA=8'hA5; exactly 8 SPICLK rises; DONE one pulse; CSB[1] high CS_HOLD cycles after the last fall.
- CMD_LEN=2, TX 8'h01,8'h02,8'h03, MISO tied 1 → three TX_READY pulses; RX bytes 8'hFF ×3; 24 rises total; CSB held low continuously.
- RX_READY held 0 after the first byte of a 2-byte command → CLK_ENABLE stays 0 and TX_READY stays 0 until RX_READY=1; then the second byte runs and no RX data is lost.
- TX_VALID withheld for 20 cycles in LOAD → SPICLK stays low and CSB stays low; the transfer resumes correctly.
- SYSRST asserted after 3 rises → all CSB high, CLK_ENABLE 0, BUSY 0, no DONE; a new command afterwards completes normally.
- SC_SPI_SEQ_LSB_FIRST_EN defined, CMD_LSB_FIRST=1, TX=8'h01 → MOSI 1 then 0 ×7; loopback RX_DATA=8'h01.
